// File: rtl/klotski_move_arbiter.sv
// klotski_move_arbiter: round-robin arbiter sharing one 4x4 Klotski board between solver and user keypad.
// Optional build macro KLOTSKI_REVERSE_FILTER_EN rejects a move that undoes the last applied move.

module klotski_move_arbiter #(
    parameter int CNT_W        = 10,
    parameter bit SOLVER_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [63:0]      i_klotski,
    input  logic             i_sol_valid,
    input  logic [1:0]       i_sol_dir,
    output logic             o_sol_ready,
    input  logic             i_usr_valid,
    input  logic [1:0]       i_usr_dir,
    output logic             o_usr_ready,
    output logic [63:0]      o_klotski,
    output logic [3:0]       o_blank_pos,
    output logic             o_move_valid,
    output logic [1:0]       o_move_dir,
    output logic             o_move_src,
    input  logic             i_move_ready,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_move_cnt,
    output logic             o_solved
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_APPLY = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;

    localparam logic [63:0]      SOLVED_BOARD = 64'h0FED_CBA9_8765_4321;
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic [2:0]       state;
    logic [63:0]      board;
    logic [3:0]       blank_pos;
    logic [CNT_W-1:0] move_cnt;
    logic             rr_ptr;
    logic             illegal_q;
    logic [1:0]       move_dir_q;
    logic             move_src_q;

    logic             scan_found;
    logic [3:0]       scan_pos;
    logic             grant_open;
    logic             both_req;
    logic             sol_grant;
    logic             usr_grant;
    logic             grant_any;
    logic [1:0]       req_dir;
    logic             geom_ok;
    logic             inverse_hit;
    logic             move_legal;
    logic [3:0]       nb_pos;

    // Lowest-index blank wins; the loop runs high to low so the last hit is the lowest index.
    always_comb begin
        scan_found = 1'b0;
        scan_pos   = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (board[4*k +: 4] == 4'd0) begin
                scan_found = 1'b1;
                scan_pos   = 4'(k);
            end
        end
    end

    // Load overrides everything, so no request is consumed in a load cycle.
    assign grant_open = (state == S_READY) && !i_load;
    assign both_req   = i_sol_valid && i_usr_valid;
    assign sol_grant  = grant_open && i_sol_valid && (!i_usr_valid || rr_ptr);
    assign usr_grant  = grant_open && i_usr_valid && (!i_sol_valid || !rr_ptr);
    assign grant_any  = sol_grant || usr_grant;
    assign req_dir    = sol_grant ? i_sol_dir : i_usr_dir;

    always_comb begin
        geom_ok = 1'b0;
        case (req_dir)
            DIR_UP:   geom_ok = (blank_pos[3:2] != 2'd0);
            DIR_DOWN: geom_ok = (blank_pos[3:2] != 2'd3);
            DIR_LEFT: geom_ok = (blank_pos[1:0] != 2'd0);
            default:  geom_ok = (blank_pos[1:0] != 2'd3);
        endcase
    end

`ifdef KLOTSKI_REVERSE_FILTER_EN
    logic       last_valid;
    logic [1:0] last_dir;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_valid <= 1'b0;
            last_dir   <= 2'd0;
        end else if (i_load) begin
            last_valid <= 1'b0;
        end else if (state == S_APPLY) begin
            last_valid <= 1'b1;
            last_dir   <= move_dir_q;
        end
    end

    // Up/down and left/right differ only in bit 0, so flipping it gives the inverse.
    assign inverse_hit = last_valid && (req_dir == (last_dir ^ 2'b01));
`else
    assign inverse_hit = 1'b0;
`endif

    assign move_legal = geom_ok && !inverse_hit;

    always_comb begin
        nb_pos = blank_pos;
        case (move_dir_q)
            DIR_UP:   nb_pos = blank_pos - 4'd4;
            DIR_DOWN: nb_pos = blank_pos + 4'd4;
            DIR_LEFT: nb_pos = blank_pos - 4'd1;
            default:  nb_pos = blank_pos + 4'd1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            board      <= 64'd0;
            blank_pos  <= 4'd0;
            move_cnt   <= '0;
            rr_ptr     <= SOLVER_FIRST;
            illegal_q  <= 1'b0;
            move_dir_q <= 2'd0;
            move_src_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (i_load) begin
                board    <= i_klotski;
                move_cnt <= '0;
                rr_ptr   <= SOLVER_FIRST;
                state    <= S_SCAN;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_SCAN: begin
                        if (scan_found) begin
                            blank_pos <= scan_pos;
                            state     <= S_READY;
                        end else begin
                            illegal_q <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_READY: begin
                        if (grant_any) begin
                            if (both_req) begin
                                rr_ptr <= !rr_ptr;
                            end
                            if (move_legal) begin
                                move_dir_q <= req_dir;
                                move_src_q <= usr_grant;
                                state      <= S_APPLY;
                            end else begin
                                illegal_q <= 1'b1;
                            end
                        end
                    end
                    // The blank slides into the neighbour, so the neighbour's tile moves into the old blank cell.
                    S_APPLY: begin
                        board[{blank_pos, 2'b00} +: 4] <= board[{nb_pos, 2'b00} +: 4];
                        board[{nb_pos, 2'b00} +: 4]    <= 4'd0;
                        blank_pos                      <= nb_pos;
                        if (move_cnt != CNT_MAX) begin
                            move_cnt <= move_cnt + 1'b1;
                        end
                        state <= S_EMIT;
                    end
                    S_EMIT: begin
                        if (i_move_ready) begin
                            state <= S_READY;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_sol_ready  = sol_grant;
    assign o_usr_ready  = usr_grant;
    assign o_klotski    = board;
    assign o_blank_pos  = blank_pos;
    assign o_move_valid = (state == S_EMIT);
    assign o_move_dir   = move_dir_q;
    assign o_move_src   = move_src_q;
    assign o_illegal    = illegal_q;
    assign o_move_cnt   = move_cnt;
    assign o_solved     = (state != S_IDLE) && (board == SOLVED_BOARD);

endmodule

// File: tb/tb_klotski_move_arbiter.sv
// tb_klotski_move_arbiter: table vectors, directed sequences and random moves against a cell-array board model.
// Honours KLOTSKI_REVERSE_FILTER_EN when it is defined for the build.

module tb_klotski_move_arbiter;

    localparam int CNT_W = 10;
    localparam int CNT_SAT = (1 << CNT_W) - 1;
    localparam logic [63:0] SOLVED = 64'h0FED_CBA9_8765_4321;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_load;
    logic [63:0]      i_klotski;
    logic             i_sol_valid;
    logic [1:0]       i_sol_dir;
    logic             o_sol_ready;
    logic             i_usr_valid;
    logic [1:0]       i_usr_dir;
    logic             o_usr_ready;
    logic [63:0]      o_klotski;
    logic [3:0]       o_blank_pos;
    logic             o_move_valid;
    logic [1:0]       o_move_dir;
    logic             o_move_src;
    logic             i_move_ready;
    logic             o_illegal;
    logic [CNT_W-1:0] o_move_cnt;
    logic             o_solved;

    klotski_move_arbiter #(.CNT_W(CNT_W), .SOLVER_FIRST(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load), .i_klotski(i_klotski),
        .i_sol_valid(i_sol_valid), .i_sol_dir(i_sol_dir), .o_sol_ready(o_sol_ready),
        .i_usr_valid(i_usr_valid), .i_usr_dir(i_usr_dir), .o_usr_ready(o_usr_ready),
        .o_klotski(o_klotski), .o_blank_pos(o_blank_pos), .o_move_valid(o_move_valid),
        .o_move_dir(o_move_dir), .o_move_src(o_move_src), .i_move_ready(i_move_ready),
        .o_illegal(o_illegal), .o_move_cnt(o_move_cnt), .o_solved(o_solved)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // Reference board: plain cell array, blank index, move count and last direction.
    int mb[16];
    int mpos;
    int mcnt;
    int mlast;
    int step_of[4] = '{-4, 4, -1, 1};
    int inv_of[4]  = '{1, 0, 3, 2};

    logic [63:0]      cap_board;
    logic [3:0]       cap_blank;
    logic [CNT_W-1:0] cap_cnt;
    logic             cap_valid, cap_src, cap_solved, cap_illegal, cap_granted;
    logic [1:0]       cap_dir;

    typedef struct {
        bit         src;
        logic [1:0] dir;
        bit         exp_illegal;
        logic [3:0] exp_blank;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void modelLoad(input logic [63:0] b);
        mpos = -1;
        for (int k = 0; k < 16; k++) mb[k] = int'(b[4*k +: 4]);
        for (int k = 15; k >= 0; k--) if (mb[k] == 0) mpos = k;
        mcnt  = 0;
        mlast = -1;
    endfunction

    function automatic logic [63:0] modelBoard();
        logic [63:0] b;
        for (int k = 0; k < 16; k++) b[4*k +: 4] = 4'(mb[k]);
        return b;
    endfunction

    function automatic bit modelSolved();
        for (int k = 0; k < 15; k++) if (mb[k] != k + 1) return 1'b0;
        return mb[15] == 0;
    endfunction

    function automatic bit modelMove(input int dir);
        int row, col, nb;
        bit ok;
        row = mpos / 4;
        col = mpos % 4;
        ok = (dir == 0 && row > 0) || (dir == 1 && row < 3) || (dir == 2 && col > 0) || (dir == 3 && col < 3);
`ifdef KLOTSKI_REVERSE_FILTER_EN
        if (ok && mlast >= 0 && dir == inv_of[mlast]) ok = 1'b0;
`endif
        if (ok) begin
            nb      = mpos + step_of[dir];
            mb[mpos] = mb[nb];
            mb[nb]   = 0;
            mpos     = nb;
            mcnt     = (mcnt + 1 > CNT_SAT) ? CNT_SAT : mcnt + 1;
            mlast    = dir;
        end
        return ok;
    endfunction

    task automatic loadBoard(input logic [63:0] b);
        i_load    = 1'b1;
        i_klotski = b;
        @(negedge i_clk); #1;
        i_load = 1'b0;
        @(negedge i_clk); #1;
        modelLoad(b);
    endtask

    // Requests one move from one side and leaves the bench at a quiet negedge afterwards.
    task automatic applyStimulus(input bit src, input logic [1:0] dir);
        cap_granted = 1'b0;
        if (src == 1'b0) begin i_sol_valid = 1'b1; i_sol_dir = dir; end
        else begin i_usr_valid = 1'b1; i_usr_dir = dir; end
        #1;
        for (int c = 0; c < 20; c++) begin
            if ((src == 1'b0 && o_sol_ready) || (src == 1'b1 && o_usr_ready)) begin
                cap_granted = 1'b1;
                break;
            end
            @(negedge i_clk); #1;
        end
        if (cap_granted) begin
            @(negedge i_clk); #1;
        end
        i_sol_valid = 1'b0;
        i_usr_valid = 1'b0;
        #1;
        cap_illegal = o_illegal;
        if (cap_granted && !cap_illegal) begin
            @(negedge i_clk); #1;
        end
        cap_board  = o_klotski;
        cap_blank  = o_blank_pos;
        cap_cnt    = o_move_cnt;
        cap_valid  = o_move_valid;
        cap_dir    = o_move_dir;
        cap_src    = o_move_src;
        cap_solved = o_solved;
        if (cap_granted) begin
            @(negedge i_clk); #1;
        end
    endtask

    task automatic checkMove(input string tag, input bit src, input logic [1:0] dir, input bit legal);
        checkOutput({tag, " granted"}, 64'(cap_granted), 64'd1);
        checkOutput({tag, " illegal"}, 64'(cap_illegal), 64'(!legal));
        checkOutput({tag, " move_valid"}, 64'(cap_valid), 64'(legal));
        checkOutput({tag, " board"}, cap_board, modelBoard());
        checkOutput({tag, " blank"}, 64'(cap_blank), 64'(mpos));
        checkOutput({tag, " cnt"}, 64'(cap_cnt), 64'(mcnt));
        checkOutput({tag, " solved"}, 64'(cap_solved), 64'(modelSolved()));
        if (legal) begin
            checkOutput({tag, " dir"}, 64'(cap_dir), 64'(dir));
            checkOutput({tag, " src"}, 64'(cap_src), 64'(src));
        end
    endtask

    initial begin
        logic [63:0] board5;
        logic [63:0] rnd_board;
        logic [63:0] nozero;
        logic [3:0]  grant_seq;
        int          n_grant;
        bit          both_seen;
        bit          legal;
        bit          got;
        int          sol_idx, usr_idx, sat_bad;
        int          perm[16];
        int          sol_dirs[2] = '{2, 3};
        int          usr_dirs[2] = '{0, 1};
        int          cyc[4] = '{0, 2, 1, 3};

        // Starts where the directed sequence leaves the board: blank 11, one move applied.
        vecs[0]  = '{1'b1, 2'd3, 1'b1, 4'd11, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 4'd10, 2};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 4'd6,  3};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 4'd2,  4};
        vecs[4]  = '{1'b1, 2'd0, 1'b1, 4'd2,  4};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 4'd1,  5};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 4'd0,  6};
        vecs[7]  = '{1'b0, 2'd2, 1'b1, 4'd0,  6};
        vecs[8]  = '{1'b1, 2'd0, 1'b1, 4'd0,  6};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 4'd4,  7};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 4'd5,  8};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 4'd9,  9};

        for (int k = 0; k < 16; k++) board5[4*k +: 4] = (k < 5) ? 4'(k + 1) : (k == 5) ? 4'd0 : 4'(k);
        nozero = 64'h1234_5678_9ABC_DEF1;

        i_rst_n = 1'b0; i_load = 1'b0; i_klotski = 64'd0;
        i_sol_valid = 1'b0; i_sol_dir = 2'd0; i_usr_valid = 1'b0; i_usr_dir = 2'd0;
        i_move_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        checkOutput("reset board", o_klotski, 64'd0);
        checkOutput("reset blank", 64'(o_blank_pos), 64'd0);
        checkOutput("reset cnt", 64'(o_move_cnt), 64'd0);
        checkOutput("reset outputs", {58'd0, o_move_valid, o_illegal, o_solved, o_move_src, o_move_dir},
                    64'd0);
        i_sol_valid = 1'b1;
        i_usr_valid = 1'b1;
        #1;
        checkOutput("idle readies", {62'd0, o_sol_ready, o_usr_ready}, 64'd0);
        i_sol_valid = 1'b0;
        i_usr_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;

        $display("[TB] load solved board");
        loadBoard(SOLVED);
        checkOutput("solved blank", 64'(o_blank_pos), 64'd15);
        checkOutput("solved flag", 64'(o_solved), 64'd1);
        checkOutput("solved cnt", 64'(o_move_cnt), 64'd0);

        applyStimulus(1'b1, 2'd3);
        legal = modelMove(3);
        checkMove("usr right at 15", 1'b1, 2'd3, legal);
        checkOutput("usr right board kept", cap_board, SOLVED);

        applyStimulus(1'b0, 2'd0);
        legal = modelMove(0);
        checkMove("sol up at 15", 1'b0, 2'd0, legal);
        checkOutput("sol up cell11", 64'(cap_board[47:44]), 64'd0);
        checkOutput("sol up cell15", 64'(cap_board[63:60]), 64'd12);
        checkOutput("sol up solved", 64'(cap_solved), 64'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].src, vecs[i].dir);
            legal = modelMove(int'(vecs[i].dir));
            checkMove($sformatf("vec%0d", i), vecs[i].src, vecs[i].dir, legal);
            checkOutput($sformatf("vec%0d tbl illegal", i), 64'(cap_illegal), 64'(vecs[i].exp_illegal));
            checkOutput($sformatf("vec%0d tbl blank", i), 64'(cap_blank), 64'(vecs[i].exp_blank));
            checkOutput($sformatf("vec%0d tbl cnt", i), 64'(cap_cnt), 64'(vecs[i].exp_cnt));
        end

        $display("[TB] round robin with both requesters");
        loadBoard(board5);
        checkOutput("rr blank", 64'(o_blank_pos), 64'd5);
        grant_seq = 4'd0; n_grant = 0; both_seen = 1'b0; sol_idx = 0; usr_idx = 0;
        i_sol_valid = 1'b1; i_sol_dir = 2'(sol_dirs[0]);
        i_usr_valid = 1'b1; i_usr_dir = 2'(usr_dirs[0]);
        #1;
        for (int c = 0; c < 60 && n_grant < 4; c++) begin
            bit gs, gu;
            gs = o_sol_ready;
            gu = o_usr_ready;
            if (gs && gu) both_seen = 1'b1;
            if (gs) begin grant_seq[n_grant] = 1'b0; n_grant++; end
            else if (gu) begin grant_seq[n_grant] = 1'b1; n_grant++; end
            @(negedge i_clk); #1;
            if (gs) begin
                void'(modelMove(sol_dirs[sol_idx]));
                sol_idx++;
                if (sol_idx < 2) i_sol_dir = 2'(sol_dirs[sol_idx]); else i_sol_valid = 1'b0;
            end else if (gu) begin
                void'(modelMove(usr_dirs[usr_idx]));
                usr_idx++;
                if (usr_idx < 2) i_usr_dir = 2'(usr_dirs[usr_idx]); else i_usr_valid = 1'b0;
            end
        end
        i_sol_valid = 1'b0;
        i_usr_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        checkOutput("rr grant count", 64'(n_grant), 64'd4);
        checkOutput("rr grant order", 64'(grant_seq), 64'b1010);
        checkOutput("rr double ready", 64'(both_seen), 64'd0);
        checkOutput("rr cnt", 64'(o_move_cnt), 64'd4);
        checkOutput("rr blank end", 64'(o_blank_pos), 64'd5);
        checkOutput("rr board", o_klotski, modelBoard());

        $display("[TB] emit stall then load");
        loadBoard(SOLVED);
        i_move_ready = 1'b0;
        i_sol_valid = 1'b1; i_sol_dir = 2'd0;
        #1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (o_sol_ready) got = 1'b1;
            else begin @(negedge i_clk); #1; end
        end
        checkOutput("stall granted", 64'(got), 64'd1);
        @(negedge i_clk); #1;
        i_sol_valid = 1'b1; i_sol_dir = 2'd2;
        i_usr_valid = 1'b1; i_usr_dir = 2'd2;
        @(negedge i_clk); #1;
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("stall%0d valid", c), 64'(o_move_valid), 64'd1);
            checkOutput($sformatf("stall%0d dir", c), 64'(o_move_dir), 64'd0);
            checkOutput($sformatf("stall%0d src", c), 64'(o_move_src), 64'd0);
            checkOutput($sformatf("stall%0d readies", c), {62'd0, o_sol_ready, o_usr_ready}, 64'd0);
            @(negedge i_clk); #1;
        end
        i_sol_valid = 1'b0; i_usr_valid = 1'b0;
        i_load = 1'b1; i_klotski = board5;
        @(negedge i_clk); #1;
        i_load = 1'b0;
        checkOutput("abort valid", 64'(o_move_valid), 64'd0);
        checkOutput("abort cnt", 64'(o_move_cnt), 64'd0);
        checkOutput("abort board", o_klotski, board5);
        @(negedge i_clk); #1;
        checkOutput("abort blank", 64'(o_blank_pos), 64'd5);
        i_move_ready = 1'b1;

        $display("[TB] up then down");
        loadBoard(SOLVED);
        applyStimulus(1'b0, 2'd0);
        legal = modelMove(0);
        checkMove("inv first", 1'b0, 2'd0, legal);
        applyStimulus(1'b0, 2'd1);
        legal = modelMove(1);
        checkMove("inv second", 1'b0, 2'd1, legal);
`ifdef KLOTSKI_REVERSE_FILTER_EN
        checkOutput("inv rejected", 64'(cap_illegal), 64'd1);
        checkOutput("inv blank", 64'(cap_blank), 64'd11);
`else
        checkOutput("inv board", cap_board, SOLVED);
        checkOutput("inv cnt", 64'(cap_cnt), 64'd2);
`endif

        $display("[TB] board without blank");
        loadBoard(nozero);
        checkOutput("nozero illegal", 64'(o_illegal), 64'd1);
        checkOutput("nozero solved", 64'(o_solved), 64'd0);
        @(negedge i_clk); #1;
        checkOutput("nozero pulse", 64'(o_illegal), 64'd0);

        $display("[TB] random moves");
        for (int k = 0; k < 16; k++) perm[k] = k;
        for (int k = 15; k > 0; k--) begin
            int j, t;
            j = int'($urandom_range(k, 0));
            t = perm[k]; perm[k] = perm[j]; perm[j] = t;
        end
        for (int k = 0; k < 16; k++) rnd_board[4*k +: 4] = 4'(perm[k]);
        loadBoard(rnd_board);
        checkOutput("rand blank", 64'(o_blank_pos), 64'(mpos));
        for (int i = 0; i < 60; i++) begin
            bit s;
            logic [1:0] d;
            s = 1'($urandom_range(1, 0));
            d = 2'($urandom_range(3, 0));
            applyStimulus(s, d);
            legal = modelMove(int'(d));
            checkMove($sformatf("rand%0d", i), s, d, legal);
        end

        $display("[TB] counter saturation");
        loadBoard(SOLVED);
        sat_bad = 0;
        for (int i = 0; i < CNT_SAT + 7; i++) begin
            applyStimulus(1'(i % 2), 2'(cyc[i % 4]));
            if (!modelMove(cyc[i % 4])) sat_bad++;
            if (!cap_granted || cap_illegal) sat_bad++;
        end
        checkOutput("sat errors", 64'(sat_bad), 64'd0);
        checkOutput("sat cnt", 64'(o_move_cnt), 64'(CNT_SAT));
        checkOutput("sat board", o_klotski, modelBoard());

        $display("[TB] reset mid-operation");
        loadBoard(SOLVED);
        i_move_ready = 1'b0;
        applyStimulus(1'b0, 2'd0);
        checkOutput("midrst emit", 64'(o_move_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst board", o_klotski, 64'd0);
        checkOutput("midrst cnt", 64'(o_move_cnt), 64'd0);
        checkOutput("midrst outputs", {54'd0, o_blank_pos, o_move_valid, o_illegal, o_solved, o_move_src,
                    o_move_dir}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_move_ready = 1'b1;
        @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
